mp_max_pack: RTL and testbench

//  Maxpooling compute stage directly downstream of the HP_2 read path.
//  - Consumes one 2x2 window per beat (mp_valid, mp_data0..3) and computes the signed max.
//  - Packs four pooled results into one 64-bit word for the write-DMA side.
//  - Drives w_full_mp back to HP_2 as almost-full backpressure.

---
 rtl/hp2_pkg.sv | 21 ++
 rtl/mp_out_fifo.sv | 82 ++++++++
 rtl/mp_max_pack.sv | 170 +++++++++++++++++
 tb/tb_mp_max_pack.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hp2_pkg
// Description : Shared widths and the signed-max helper for the HP_2
//               maxpooling stage.
// Revision    : 1.0 - initial release
// ============================================================================
package hp2_pkg;

  localparam int DATA_W   = 16;
  localparam int MP_LANES = 4;
  localparam int OFM_W    = DATA_W * MP_LANES;

  // Two's-complement maximum; on a tie either operand is correct.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mp_out_fifo
// Description : First-word-fall-through output FIFO. The head entry is always
//               presented on o_data. A push into a full FIFO is still taken
//               when a pop happens in the same cycle. Otherwise the word is
//               dropped and o_overflow is raised for that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_out_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count_next,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = i_pop && (r_count != '0) && !i_clr;
  assign w_wr       = i_push && !i_clr && (!w_full || w_pop);
  assign o_overflow = i_push && !i_clr && w_full && !w_pop;
  assign o_valid    = (r_count != '0);
  assign o_data     = r_mem[r_rd_ptr];

  // Occupancy after this edge; also feeds the registered almost-full flag.
  always_comb begin
    o_count_next = r_count;
    if (i_clr) begin
      o_count_next = '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   o_count_next = r_count + 1'b1;
        2'b01:   o_count_next = r_count - 1'b1;
        default: o_count_next = r_count;
      endcase
    end
  end

  // Pointer and occupancy registers; a clear empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_clr) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= o_count_next;
    end
  end

  // Storage array; contents need no reset because the count qualifies them.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/mp_max_pack.sv
`default_nettype none
// ============================================================================
// Module      : mp_max_pack
// Description : 2x2 signed maxpool (two register stages) followed by a
//               four-lane packer into 64-bit words, the output FIFO, the
//               almost-full backpressure flag, the last-word tagging and the
//               sticky overflow error.
// Revision    : 1.0 - initial release
// ============================================================================
module mp_max_pack
  import hp2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_maxpooling,
  input  logic              ap_start,
  input  logic [19:0]       ofm_words,
  input  logic              mp_flush,
  input  logic              mp_valid,
  input  logic [DATA_W-1:0] mp_data0,
  input  logic [DATA_W-1:0] mp_data1,
  input  logic [DATA_W-1:0] mp_data2,
  input  logic [DATA_W-1:0] mp_data3,
  output logic              w_full_mp,
  output logic              ofm_valid,
  input  logic              ofm_ready,
  output logic [OFM_W-1:0]  ofm_data,
  output logic              ofm_last,
  output logic              mp_done,
  output logic              err_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] c_AF_LEVEL = CW'(FIFO_DEPTH - AF_MARGIN);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_m01;
  logic [DATA_W-1:0] r_m23;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_max;
  logic [DATA_W-1:0] r_lane [MP_LANES];
  logic [1:0]        r_idx;
  logic [19:0]       r_wcnt;
  logic              r_full;
  logic              r_err;
  logic              r_done;

  logic              w_accept;
  logic [2:0]        w_fill;
  logic [DATA_W-1:0] w_lane [MP_LANES];
  logic              w_push;
  logic              w_last;
  logic [OFM_W:0]    w_fifo_din;
  logic [OFM_W:0]    w_fifo_dout;
  logic              w_fifo_valid;
  logic [CW-1:0]     w_count_next;
  logic              w_ovf;
  logic              w_pop;

  assign w_accept = mp_valid && is_maxpooling;

  // Stage 1: pairwise maxima of the upper and lower pixel rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_m01      <= '0;
      r_m23      <= '0;
    end else begin
      r_s1_valid <= w_accept && !ap_start;
      if (w_accept) begin
        r_m01 <= smax(mp_data0, mp_data1);
        r_m23 <= smax(mp_data2, mp_data3);
      end
    end
  end

  // Stage 2: final window maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_max      <= '0;
    end else begin
      r_s2_valid <= r_s1_valid && !ap_start;
      if (r_s1_valid) r_max <= smax(r_m01, r_m23);
    end
  end

  // Word image as it stands after this cycle's S2 result; lanes at or beyond
  // the fill level read as zero so a flushed partial word is zero-padded.
  always_comb begin
    w_fill = {1'b0, r_idx} + {2'b00, r_s2_valid};
    for (int k = 0; k < MP_LANES; k++) begin
      w_lane[k] = '0;
      if (3'(k) < w_fill) begin
        if (r_s2_valid && (r_idx == 2'(k))) w_lane[k] = r_max;
        else                                 w_lane[k] = r_lane[k];
      end
    end
  end

  assign w_push     = !ap_start && ((r_s2_valid && (r_idx == 2'd3)) ||
                                    (mp_flush && (w_fill != 3'd0)));
  assign w_last     = mp_flush || (r_wcnt == (ofm_words - 20'd1));
  assign w_fifo_din = {w_last, w_lane[0], w_lane[1], w_lane[2], w_lane[3]};

  // Packer lane registers, lane index and per-layer word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_wcnt <= '0;
      for (int k = 0; k < MP_LANES; k++) r_lane[k] <= '0;
    end else if (ap_start) begin
      r_idx  <= '0;
      r_wcnt <= '0;
    end else begin
      if (r_s2_valid) begin
        for (int k = 0; k < MP_LANES; k++) begin
          if (r_idx == 2'(k)) r_lane[k] <= r_max;
        end
      end
      if (w_push)          r_idx <= '0;
      else if (r_s2_valid) r_idx <= r_idx + 1'b1;
      if (w_push) r_wcnt <= w_last ? 20'd0 : (r_wcnt + 20'd1);
    end
  end

  mp_out_fifo #(
    .WIDTH (OFM_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (ap_start),
    .i_push       (w_push),
    .i_data       (w_fifo_din),
    .i_pop        (ofm_ready),
    .o_data       (w_fifo_dout),
    .o_valid      (w_fifo_valid),
    .o_count_next (w_count_next),
    .o_overflow   (w_ovf)
  );

  assign w_pop = w_fifo_valid && ofm_ready;

  // Status flags: almost-full tracks the new occupancy, overflow is sticky
  // until the next layer start, done marks the pop of a last-tagged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_full <= (w_count_next >= c_AF_LEVEL);
      r_err  <= ap_start ? 1'b0 : (r_err || w_ovf);
      r_done <= w_pop && w_fifo_dout[OFM_W];
    end
  end

  assign w_full_mp    = r_full;
  assign err_overflow = r_err;
  assign mp_done      = r_done;
  assign ofm_valid    = w_fifo_valid;
  assign ofm_data     = w_fifo_valid ? w_fifo_dout[OFM_W-1:0] : '0;
  assign ofm_last     = w_fifo_valid && w_fifo_dout[OFM_W];

endmodule
`default_nettype wire

// File: tb/tb_mp_max_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_mp_max_pack
// Description : Self-checking bench for mp_max_pack. A cycle monitor keeps a
//               transaction-level model (time-stamped pooled results, a list
//               of pending lanes, a word queue for the FIFO) and compares the
//               DUT outputs every cycle; directed tables and sequences cover
//               the known-answer and corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mp_max_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_maxpooling;
  logic        ap_start;
  logic [19:0] ofm_words;
  logic        mp_flush;
  logic        mp_valid;
  logic [15:0] mp_data0, mp_data1, mp_data2, mp_data3;
  logic        w_full_mp;
  logic        ofm_valid;
  logic        ofm_ready;
  logic [63:0] ofm_data;
  logic        ofm_last;
  logic        mp_done;
  logic        err_overflow;

  mp_max_pack dut (
    .clk           (clk),
    .rst           (rst),
    .is_maxpooling (is_maxpooling),
    .ap_start      (ap_start),
    .ofm_words     (ofm_words),
    .mp_flush      (mp_flush),
    .mp_valid      (mp_valid),
    .mp_data0      (mp_data0),
    .mp_data1      (mp_data1),
    .mp_data2      (mp_data2),
    .mp_data3      (mp_data3),
    .w_full_mp     (w_full_mp),
    .ofm_valid     (ofm_valid),
    .ofm_ready     (ofm_ready),
    .ofm_data      (ofm_data),
    .ofm_last      (ofm_last),
    .mp_done       (mp_done),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] v; int t; } res_t;
  typedef struct { logic [63:0] d; bit last; } word_t;

  res_t        rq[$];
  logic [15:0] cur[$];
  word_t       mq[$];
  int          wcnt  = 0;
  bit          merr  = 0;
  bit          mdone = 0;
  int          cyc   = 0;
  int          npops = 0;

  function automatic logic [15:0] max4(input logic [63:0] w);
    logic signed [15:0] m;
    logic signed [15:0] x;
    m = w[63:48];
    for (int k = 1; k < 4; k++) begin
      x = w[63-16*k -: 16];
      if (x > m) m = x;
    end
    return m;
  endfunction

  function automatic word_t mkword(input bit fl);
    word_t r;
    r.d = '0;
    for (int k = 0; k < cur.size(); k++) r.d[63-16*k -: 16] = cur[k];
    r.last = fl || (wcnt == int'(ofm_words) - 1);
    wcnt   = r.last ? 0 : wcnt + 1;
    cur.delete();
    return r;
  endfunction

  always @(negedge clk) begin
    word_t pw;
    bit    have_push;
    bit    pop;
    bit    ndone;
    int    nsz;
    if (rst) begin
      rq.delete(); cur.delete(); mq.delete();
      wcnt = 0; merr = 0; mdone = 0;
      chk("rst_valid", ofm_valid, 0);
      chk("rst_data", ofm_data, 0);
      chk("rst_full", w_full_mp, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_done", mp_done, 0);
    end else begin
      chk("m_valid", ofm_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("m_data", ofm_data, mq[0].d);
        chk("m_last", ofm_last, mq[0].last);
      end
      chk("m_full", w_full_mp, mq.size() >= 6);
      chk("m_err", err_overflow, merr);
      chk("m_done", mp_done, mdone);

      pop   = ofm_ready && (mq.size() > 0);
      ndone = pop && mq[0].last;
      have_push = 0;
      while (rq.size() > 0 && rq[0].t == cyc) begin
        cur.push_back(rq[0].v);
        void'(rq.pop_front());
        if (cur.size() == 4) begin pw = mkword(1'b0); have_push = 1; end
      end
      if (mp_flush && cur.size() > 0) begin pw = mkword(1'b1); have_push = 1; end
      if (mp_valid && is_maxpooling)
        rq.push_back('{max4({mp_data0, mp_data1, mp_data2, mp_data3}), cyc + 2});
      if (ap_start) begin
        rq.delete(); cur.delete(); mq.delete();
        wcnt = 0; merr = 0;
      end else begin
        nsz = mq.size();
        if (pop) begin npops++; void'(mq.pop_front()); end
        if (have_push) begin
          if (nsz < 8 || pop) mq.push_back(pw);
          else                merr = 1;
        end
      end
      mdone = ndone;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc1();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc1();
  endtask

  task automatic send(input logic [63:0] w);
    mp_valid = 1'b1;
    {mp_data0, mp_data1, mp_data2, mp_data3} = w;
    cyc1();
    mp_valid = 1'b0;
  endtask

  task automatic pulse_start();
    ap_start = 1'b1;
    cyc1();
    ap_start = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    for (int i = 0; i < lim && !ofm_valid; i++) cyc1();
    chk(nm, ofm_valid, 1);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  typedef struct {
    logic [3:0][63:0] win;
    logic [63:0]      exp;
  } vec_t;

  vec_t vec [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent, stall, guard, p0;
    bit saw_full;

    vec[0].win[0] = 64'h0001_0005_FFFD_0002;
    vec[0].win[1] = 64'h8000_7FFF_0000_0000;
    vec[0].win[2] = 64'hFFFF_FFFE_FFFD_FFFC;
    vec[0].win[3] = 64'h0007_0007_0007_0007;
    vec[0].exp    = 64'h0005_7FFF_FFFF_0007;
    vec[1].win[0] = 64'hFF9C_FF38_FFCE_FED4;
    vec[1].win[1] = 64'h0000_0000_0000_0000;
    vec[1].win[2] = 64'h8000_8000_8000_8001;
    vec[1].win[3] = 64'h1234_F000_0FFF_1235;
    vec[1].exp    = 64'hFFCE_0000_8001_1235;
    vec[2].win[0] = 64'h7FFF_8000_8000_8000;
    vec[2].win[1] = 64'h8000_8000_8000_7FFF;
    vec[2].win[2] = 64'h0003_FFFD_0002_FFFE;
    vec[2].win[3] = 64'hFFFE_FFFD_FFFF_FFFC;
    vec[2].exp    = 64'h7FFF_7FFF_0003_FFFF;

    rst = 1'b1; is_maxpooling = 1'b1; ap_start = 1'b0; ofm_words = 20'd1;
    mp_flush = 1'b0; mp_valid = 1'b0; ofm_ready = 1'b0;
    {mp_data0, mp_data1, mp_data2, mp_data3} = '0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("reset_valid", ofm_valid, 0);
    chk("reset_last", ofm_last, 0);
    chk("reset_data", ofm_data, 0);
    chk("reset_err", err_overflow, 0);

    // Known-answer words, one word per layer (ofm_words=1).
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) send(vec[i].win[k]);
      if (i == 0) begin
        cyc1();
        chk("latency_early", ofm_valid, 0);
        cyc1();
        chk("latency_3cyc", ofm_valid, 1);
      end else begin
        wait_valid("tbl_wait", 10);
      end
      chk("tbl_data", ofm_data, vec[i].exp);
      chk("tbl_last", ofm_last, 1);
      ofm_ready = 1'b1;
      cyc1();
      chk("tbl_done", mp_done, 1);
      ofm_ready = 1'b0;
      cyc1();
      chk("tbl_done_pulse", mp_done, 0);
    end

    // Backpressure: 40 random windows into a stalled sink, upstream obeys.
    pulse_start();
    ofm_words = 20'd10;
    p0 = npops; sent = 0; stall = 0; guard = 0; saw_full = 0;
    while (sent < 40 && guard < 2000) begin
      guard++;
      if (w_full_mp) begin
        saw_full = 1;
        stall++;
        if (stall >= 10) ofm_ready = 1'b1;
        cyc1();
      end else begin
        send(rnd64());
        sent++;
      end
    end
    chk("bp_sent", sent, 40);
    chk("bp_saw_full", saw_full, 1);
    ofm_ready = 1'b1;
    for (int i = 0; i < 100 && npops - p0 < 10; i++) cyc1();
    chk("bp_words", npops - p0, 10);
    chk("bp_no_ovf", err_overflow, 0);
    ofm_ready = 1'b0;

    // Flush of a partial word after six windows.
    pulse_start();
    ofm_words = 20'd100;
    for (int k = 10; k < 16; k++) send(64'(k) << 48);
    idle(3);
    mp_flush = 1'b1;
    cyc1();
    mp_flush = 1'b0;
    cyc1();
    chk("fl_word1", ofm_data, 64'h000A_000B_000C_000D);
    chk("fl_word1_last", ofm_last, 0);
    ofm_ready = 1'b1;
    cyc1();
    chk("fl_word2", ofm_data, 64'h000E_000F_0000_0000);
    chk("fl_word2_last", ofm_last, 1);
    cyc1();
    ofm_ready = 1'b0;
    chk("fl_empty", ofm_valid, 0);
    chk("fl_done", mp_done, 1);
    for (int k = 1; k < 5; k++) send(64'(k) << 32);
    wait_valid("fl_next_wait", 10);
    chk("fl_next_lane0", ofm_data, 64'h0001_0002_0003_0004);
    ofm_ready = 1'b1;
    cyc1();
    ofm_ready = 1'b0;

    // Full FIFO: simultaneous push/pop, then push without pop.
    pulse_start();
    ofm_words = 20'd1000;
    for (int k = 0; k < 32; k++) send(rnd64());
    idle(3);
    chk("full_flag", w_full_mp, 1);
    for (int k = 0; k < 4; k++) send(rnd64());
    cyc1();
    ofm_ready = 1'b1;
    cyc1();
    ofm_ready = 1'b0;
    chk("full_pushpop_err", err_overflow, 0);
    chk("full_pushpop_flag", w_full_mp, 1);
    for (int k = 0; k < 4; k++) send(rnd64());
    idle(3);
    chk("ovf_set", err_overflow, 1);
    idle(5);
    chk("ovf_sticky", err_overflow, 1);
    pulse_start();
    chk("ovf_cleared", err_overflow, 0);
    chk("clr_empty", ofm_valid, 0);

    // Asynchronous reset mid-word (three words queued, lane index 2).
    pulse_start();
    for (int k = 0; k < 14; k++) send(rnd64());
    idle(3);
    rst = 1'b1;
    #1;
    chk("arst_valid", ofm_valid, 0);
    chk("arst_full", w_full_mp, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc1();
    send(64'h0000_0000_0011_0000);
    send(64'h0022_FFFF_8000_0000);
    send(64'h8000_0033_0000_0000);
    send(64'h0000_0000_0000_0044);
    wait_valid("arst_next_wait", 10);
    chk("arst_next_lane0", ofm_data, 64'h0011_0022_0033_0044);
    ofm_ready = 1'b1;
    cyc1();
    ofm_ready = 1'b0;

    // Layer not in maxpool mode: windows are ignored.
    is_maxpooling = 1'b0;
    for (int k = 0; k < 8; k++) send(rnd64());
    idle(4);
    chk("nomp_valid", ofm_valid, 0);
    is_maxpooling = 1'b1;

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
